// File: rtl/serial_frame_loader.sv
// Deserialises framed MSB-first serial words with optional parity and emits a
// one-cycle load strobe (or parity_error strobe) when each frame completes.
module serial_frame_loader #(
  parameter int WIDTH      = 8,
  parameter int PARITY_EN  = 1,
  parameter int ODD_PARITY = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_start,
  input  logic             serial_valid,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             load_enable,
  output logic             parity_error,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic PARITY_TARGET = (ODD_PARITY != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t           state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] shift_q,  shift_d;
  logic [WIDTH-1:0] data_q,   data_d;
  logic             load_q,   load_d;
  logic             perr_q,   perr_d;
  logic             busy_q,   busy_d;

  logic [WIDTH-1:0] shifted;
  logic             parity_ok;

  assign shifted   = {shift_q[WIDTH-2:0], serial_in};
  assign parity_ok = ((^shift_q) ^ serial_in) == PARITY_TARGET;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    load_d  = 1'b0;
    perr_d  = 1'b0;

    // A new frame_start always wins, aborting any frame in progress silently.
    if (frame_start) begin
      state_d = SHIFT;
      cnt_d   = '0;
      shift_d = '0;
    end else begin
      case (state_q)
        SHIFT: begin
          if (serial_valid) begin
            shift_d = shifted;
            if (cnt_q == LAST_BIT) begin
              cnt_d = '0;
              if (PARITY_EN != 0) begin
                state_d = PARITY;
              end else begin
                state_d = IDLE;
                data_d  = shifted;
                load_d  = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        PARITY: begin
          if (serial_valid) begin
            state_d = IDLE;
            if (parity_ok) begin
              data_d = shift_q;
              load_d = 1'b1;
            end else begin
              perr_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      load_q  <= 1'b0;
      perr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      load_q  <= load_d;
      perr_q  <= perr_d;
      busy_q  <= busy_d;
    end
  end

  assign data_out     = data_q;
  assign load_enable  = load_q;
  assign parity_error = perr_q;
  assign busy         = busy_q;

endmodule
